cpu_regfile: RTL

Architectural register file and processor status register for the 6502 core. It sits directly downstream of the ALU and is the write-back stage for `portOut` and `statusUpdt`. It holds A, X, Y, SP and P, applies per-instruction flag masks, and performs stack-pointer increment and decrement. It also produces the push image of P and the one-instruction-delayed IRQ mask that the control unit samples.

---
 rtl/cpu_regfile_if.sv | 47 ++++
 rtl/cpu_regfile.sv | 87 ++++++++
 2 files changed

// File: rtl/cpu_regfile_if.sv
// rtl/cpu_regfile_if.sv - status register type and bus interface for the 6502 register file
package cpu_regfile_pkg;
  typedef struct packed {
    logic negative;
    logic overflow;
    logic unused;
    logic brk;
    logic decimal;
    logic irq;
    logic zero;
    logic carry;
  } statusReg_t;
endpackage

interface cpu_regfile_if;
  import cpu_regfile_pkg::*;

  logic       wrEn;
  logic [2:0] wrDest;
  logic [7:0] wrData;
  statusReg_t flagUpdt;
  logic [7:0] flagMask;
  logic [7:0] forceMask;
  logic [7:0] forceVal;
  logic [1:0] spOp;
  logic       pushBrk;
  logic       instrEnd;
  logic [7:0] regA;
  logic [7:0] regX;
  logic [7:0] regY;
  logic [7:0] regSP;
  statusReg_t status;
  logic [7:0] statusPush;
  logic       irqMask;

  modport master (
    output wrEn, wrDest, wrData, flagUpdt, flagMask, forceMask, forceVal,
           spOp, pushBrk, instrEnd,
    input  regA, regX, regY, regSP, status, statusPush, irqMask
  );

  modport slave (
    input  wrEn, wrDest, wrData, flagUpdt, flagMask, forceMask, forceVal,
           spOp, pushBrk, instrEnd,
    output regA, regX, regY, regSP, status, statusPush, irqMask
  );
endinterface

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 6502 A/X/Y/SP/P write-back stage with flag masking and delayed IRQ mask
module cpu_regfile
  import cpu_regfile_pkg::*;
#(
  parameter logic [7:0] SP_RESET = 8'hFD,
  parameter logic [7:0] P_RESET  = 8'h34
) (
  input  logic          clk,
  input  logic          rst,
  cpu_regfile_if.slave  bus
);

  localparam logic [2:0] DEST_A  = 3'd0;
  localparam logic [2:0] DEST_X  = 3'd1;
  localparam logic [2:0] DEST_Y  = 3'd2;
  localparam logic [2:0] DEST_SP = 3'd3;
  localparam logic [2:0] DEST_P  = 3'd4;

  localparam logic [7:0] P_INIT = {P_RESET[7:6], 2'b10, P_RESET[3:0]};

  logic [7:0] reg_a;
  logic [7:0] reg_x;
  logic [7:0] reg_y;
  logic [7:0] reg_sp;
  logic [7:0] reg_p;
  logic       irq_mask;
  logic [7:0] p_next;
  logic [7:0] upd;

  assign upd = bus.flagUpdt;

  // Loading P (PLP/RTI) overrides all flag masking; otherwise force beats copy.
  always_comb begin
    p_next = reg_p;
    if (bus.wrEn && bus.wrDest == DEST_P) begin
      p_next = bus.wrData;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (bus.forceMask[b])
          p_next[b] = bus.forceVal[b];
        else if (bus.flagMask[b])
          p_next[b] = upd[b];
      end
    end
    p_next[5] = 1'b1;
    p_next[4] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a    <= 8'h00;
      reg_x    <= 8'h00;
      reg_y    <= 8'h00;
      reg_sp   <= SP_RESET;
      reg_p    <= P_INIT;
      irq_mask <= 1'b1;
    end else begin
      reg_p <= p_next;
      if (bus.instrEnd)
        irq_mask <= reg_p[2];
      if (bus.wrEn && bus.wrDest == DEST_A)
        reg_a <= bus.wrData;
      if (bus.wrEn && bus.wrDest == DEST_X)
        reg_x <= bus.wrData;
      if (bus.wrEn && bus.wrDest == DEST_Y)
        reg_y <= bus.wrData;
      if (bus.wrEn && bus.wrDest == DEST_SP) begin
        reg_sp <= bus.wrData;
      end else begin
        case (bus.spOp)
          2'b01:   reg_sp <= reg_sp + 8'd1;
          2'b10:   reg_sp <= reg_sp - 8'd1;
          default: reg_sp <= reg_sp;
        endcase
      end
    end
  end

  assign bus.regA       = reg_a;
  assign bus.regX       = reg_x;
  assign bus.regY       = reg_y;
  assign bus.regSP      = reg_sp;
  assign bus.status     = statusReg_t'(reg_p);
  assign bus.statusPush = {reg_p[7:6], 1'b1, bus.pushBrk, reg_p[3:0]};
  assign bus.irqMask    = irq_mask;

endmodule
